stim_harness: RTL and testbench

STIM_HARNESS -- requirements
Module: stim_harness

---
 rtl/stim_harness.sv | 132 +++++++++++++
 tb/tb_stim_harness.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stim_harness.sv
// Serial-loaded stimulus harness: shifts a stimulus frame in on rx, applies it,
// compacts RUN_LEN response vectors into a MISR signature and shifts it out on tx.
module stim_harness #(
  parameter int                SW      = 64,
  parameter int                RW      = 64,
  parameter int                MISR_W  = 32,
  parameter logic [MISR_W-1:0] POLY    = 32'h0040_0007,
  parameter int                RUN_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic          tx,
  output logic [SW-1:0] stim_out,
  output logic          stim_valid,
  input  logic [RW-1:0] resp_in,
  output logic          busy
);

  localparam int MAX_A = (SW > RUN_LEN) ? SW : RUN_LEN;
  localparam int MAX_N = (MAX_A > MISR_W) ? MAX_A : MISR_W;
  localparam int CW    = $clog2(MAX_N + 1);
  localparam int NCH   = (RW + MISR_W - 1) / MISR_W;
  localparam int PW    = NCH * MISR_W;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(SW - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] DUMP_LAST  = CW'(MISR_W - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, APPLY, RUN, DUMP} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     shadow_q;
  logic [SW-1:0]     stim_out_q;
  logic              stim_valid_q;
  logic [MISR_W-1:0] misr_q;
  logic [MISR_W-1:0] misr_d;
  logic              tx_q;
  logic              busy_q;

  // Response is zero-padded up to whole MISR_W chunks, then the chunks are XOR-folded.
  logic [PW-1:0]     resp_pad;
  logic [MISR_W-1:0] chunk [NCH];
  logic [MISR_W-1:0] fold;

  assign resp_pad = PW'(resp_in);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    assign chunk[gi] = resp_pad[gi*MISR_W +: MISR_W];
  end

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ chunk[i];
    misr_d = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? POLY : '0) ^ fold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      stim_out_q   <= '0;
      stim_valid_q <= 1'b0;
      misr_q       <= '1;
      tx_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          shadow_q <= {shadow_q[SW-2:0], rx};
          if (cnt_q == SHIFT_LAST) begin
            stim_out_q   <= {shadow_q[SW-2:0], rx};
            stim_valid_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= APPLY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        APPLY: begin
          stim_valid_q <= 1'b0;
          misr_q       <= '1;
          cnt_q        <= '0;
          state_q      <= RUN;
        end
        RUN: begin
          misr_q <= misr_d;
          if (cnt_q == RUN_LAST) begin
            // First signature bit must already be on tx in the first DUMP cycle.
            tx_q    <= misr_d[MISR_W-1];
            cnt_q   <= '0;
            state_q <= DUMP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DUMP: begin
          if (cnt_q == DUMP_LAST) begin
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            misr_q <= {misr_q[MISR_W-2:0], 1'b0};
            tx_q   <= misr_q[MISR_W-2];
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign stim_out   = stim_out_q;
  assign stim_valid = stim_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_stim_harness.sv
// Randomized and directed bench for stim_harness with a frame-timeline reference model.
module tb_stim_harness;

  localparam int SW  = 8;
  localparam int RW  = 16;
  localparam int MW  = 8;
  localparam int RL  = 2;
  localparam logic [MW-1:0] POLY = 8'h1D;
  localparam int TX0 = SW + RL + 2;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic          tx;
  logic [SW-1:0] stim_out;
  logic          stim_valid;
  logic [RW-1:0] resp_in;
  logic          busy;

  int tests = 0;
  int fails = 0;

  stim_harness #(
    .SW(SW), .RW(RW), .MISR_W(MW), .POLY(POLY), .RUN_LEN(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .stim_out(stim_out),
    .stim_valid(stim_valid), .resp_in(resp_in), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Signature step from the arithmetic definition: every response bit k folds into bit k mod MW.
  function automatic logic [MW-1:0] mstep(input logic [MW-1:0] m, input logic [RW-1:0] r);
    logic [MW-1:0] f;
    f = '0;
    for (int k = 0; k < RW; k++) f[k % MW] = f[k % MW] ^ r[k];
    return {m[MW-2:0], 1'b0} ^ (m[MW-1] ? POLY : '0) ^ f;
  endfunction

  // Reference model: p is the current cycle's offset from the start-bit cycle, -1 when idle.
  int            p = -1;
  logic [SW-1:0] coll = '0;
  logic [SW-1:0] exp_stim = '0;
  logic [MW-1:0] sig = '1;

  always @(negedge clk) begin
    if (!rst_n) begin
      p        = -1;
      coll     = '0;
      exp_stim = '0;
    end else begin
      check("m_busy", busy, (p >= 1) ? 1 : 0);
      check("m_valid", stim_valid, (p == SW + 1) ? 1 : 0);
      check("m_stim", stim_out, exp_stim);
      check("m_tx", tx, (p >= TX0 && p < TX0 + MW) ? sig[MW-1-(p-TX0)] : 1'b0);
      if (p < 0) begin
        if (rx) begin
          p    = 1;
          coll = '0;
        end
      end else begin
        if (p <= SW) coll = {coll[SW-2:0], rx};
        if (p >= SW + 2 && p <= SW + 1 + RL) sig = mstep(sig, resp_in);
        p++;
        if (p == SW + 1) begin
          exp_stim = coll;
          sig      = '1;
        end
        if (p == TX0 + MW) p = -1;
      end
    end
  end

  task automatic cyc(input logic r, input logic [RW-1:0] resp);
    @(posedge clk);
    #1;
    rx      = r;
    resp_in = resp;
    @(negedge clk);
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [RW-1:0] rresp();
    return RW'($urandom);
  endfunction

  task automatic run_frame(input string tag, input logic [SW-1:0] stim,
                           input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                           input logic [MW-1:0] exp_sig);
    logic [MW-1:0] txb;
    cyc(1'b1, rresp());
    for (int i = 0; i < SW; i++) cyc(stim[SW-1-i], rresp());
    cyc(rbit(), rresp());
    check({tag, "_valid"}, stim_valid, 1);
    check({tag, "_stim"}, stim_out, stim);
    cyc(rbit(), r0);
    cyc(rbit(), r1);
    txb = '0;
    for (int i = 0; i < MW; i++) begin
      cyc(rbit(), rresp());
      txb = {txb[MW-2:0], tx};
    end
    check({tag, "_sig"}, txb, exp_sig);
    cyc(1'b0, rresp());
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tx_end"}, tx, 0);
    $display("[TB] frame %s stim=%h sig=%h", tag, stim_out, txb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst_n   = 1'b0;
    rx      = 1'b0;
    resp_in = '0;
    #3;
    check("rst_tx", tx, 0);
    check("rst_stim", stim_out, 0);
    check("rst_valid", stim_valid, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    check("pin_ff_00", mstep(8'hFF, 16'h0000), 8'hE3);
    check("pin_e3_00", mstep(8'hE3, 16'h0000), 8'hDB);
    check("pin_ff_ff", mstep(8'hFF, 16'h00FF), 8'h1C);
    check("pin_1c_ff", mstep(8'h1C, 16'h00FF), 8'hC7);
    check("pin_fold0f0f", mstep(8'hFF, 16'h0F0F), 8'hE3);

    run_frame("zero", 8'hA5, 16'h0000, 16'h0000, 8'hDB);
    run_frame("ones", 8'hA5, 16'h00FF, 16'h00FF, 8'hC7);
    run_frame("fold", 8'h3C, 16'h0F0F, 16'h0F0F, 8'hDB);

    for (int i = 0; i < 400; i++) cyc(($urandom_range(0, 7) == 0), rresp());
    repeat (TX0 + MW + 2) cyc(1'b0, rresp());

    // Abort a frame in its second RUN cycle.
    cyc(1'b1, rresp());
    for (int i = 0; i < SW; i++) cyc(rbit(), rresp());
    cyc(rbit(), rresp());
    cyc(rbit(), rresp());
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 0);
    check("arst_stim", stim_out, 0);
    check("arst_valid", stim_valid, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rx = 1'b0;
    @(negedge clk);
    repeat (3) cyc(1'b0, rresp());
    run_frame("after_rst", 8'hA5, 16'h0000, 16'h0000, 8'hDB);

    pulses = 0;
    for (int i = 0; i < 3 * (TX0 + MW); i++) begin
      cyc(1'b1, rresp());
      if (stim_valid === 1'b1 && stim_out === 8'hFF) pulses++;
    end
    check("b2b_pulses", pulses, 3);
    repeat (TX0 + MW + 2) cyc(1'b0, rresp());
    check("b2b_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
